instr_encoder: RTL and testbench

Sequential RISC-V RV32I instruction encoder: the write-side counterpart of the instruction decoder. It accepts field-level encode requests (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and emits packed 32-bit instruction words through a registered valid/ready output stage. It also expands the `LI` pseudo-instruction into one or two words. It sits between the debug/boot sequencer and the instruction-injection port of the fetch stage.

---
 rtl/riscv_enc_pkg.sv | 44 ++++
 rtl/instr_field_pack.sv | 39 +++
 rtl/instr_encoder.sv | 230 +++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_enc_pkg
// Shared types and constants for the RV32I instruction encoder.
//   fmt_e        : request format codes carried on in_fmt
//   OPC_*        : RV32I major opcodes
//   state_e      : encoder output-stage state
//   fits_simm12  : true when a 32-bit value sign-extends from 12 bits
// -----------------------------------------------------------------------------
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_LI_HI = 2'd2,
        ST_LI_LO = 2'd3
    } state_e;

    // Bits 31..11 all equal means the value survives a 12-bit sign-extension.
    function automatic logic fits_simm12(input logic [31:0] v);
        return (&v[31:11]) | ~(|v[31:11]);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
// Purely combinational packer: format + instruction fields -> 32-bit word.
//   fmt_i               : R/I/S/B/U/J (anything else packs to zero)
//   opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i : raw fields
//   imm_i               : immediate in byte/value units; unused bits ignored
//   instr_o             : packed instruction word
// -----------------------------------------------------------------------------
module instr_field_pack
    import riscv_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        instr_o = '0;
        case (fmt_i)
            FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                              rd_i, opcode_i};
            default: instr_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Sequential RV32I instruction encoder with a registered valid/ready output.
// Optional feature macro: INSTR_ENCODER_LI_EN (LI pseudo-instruction expansion).
// Without it, fmt=6 is treated as reserved and dropped with an err pulse.
//   clk, rst_n          : clock (rising), async active-low reset
//   in_valid/in_ready   : request handshake
//   in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm
//                       : request fields
//   out_valid/out_ready : output handshake
//   out_instr, out_last : encoded word, final word of its request
//   err                 : one-cycle pulse, request dropped
//   emit_count          : words handed off (wraps)
// -----------------------------------------------------------------------------
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_last,
    output logic               err,
    output logic [COUNT_W-1:0] emit_count
);

    fmt_e               req_fmt;
    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               accept, out_hs, load_new;
    logic               req_err, req_two;

    // Inputs to the packer producing the first (often only) word of a request.
    fmt_e               p_fmt;
    logic [6:0]         p_opcode;
    logic [2:0]         p_funct3;
    logic [6:0]         p_funct7;
    logic [4:0]         p_rs1, p_rs2;
    logic [31:0]        p_imm;
    logic [31:0]        first_word;

    assign req_fmt  = fmt_e'(in_fmt);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign load_new = accept && !req_err;

`ifdef INSTR_ENCODER_LI_EN
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        li_sext;
    logic [31:0] lo_word_q, lo_word_d, addi_word;

    // Rounded upper part so that LUI hi + sign-extended lo rebuilds imm.
    assign li_hi   = 20'((in_imm + 32'h0000_0800) >> 12);
    assign li_lo   = in_imm[11:0];
    assign li_sext = fits_simm12(in_imm);
    assign req_two = (req_fmt == FMT_LI) && !li_sext && (li_lo != 12'd0);

    // Second word of a two-word LI: ADDI rd, rd, lo.
    instr_field_pack u_pack_lo (
        .fmt_i    (FMT_I),
        .opcode_i (OPC_OP_IMM),
        .funct3_i (3'd0),
        .funct7_i (7'd0),
        .rd_i     (in_rd),
        .rs1_i    (in_rd),
        .rs2_i    (5'd0),
        .imm_i    ({20'd0, li_lo}),
        .instr_o  (addi_word)
    );
`else
    assign req_two = 1'b0;
`endif

    always_comb begin
        req_err = 1'b0;
        case (req_fmt)
            FMT_B, FMT_J: req_err = in_imm[0];
            FMT_RSV:      req_err = 1'b1;
`ifndef INSTR_ENCODER_LI_EN
            FMT_LI:       req_err = 1'b1;
`endif
            default:      req_err = 1'b0;
        endcase
    end

    // LI reuses the packer: ADDI rd,x0,lo for small values, else LUI rd,hi.
    always_comb begin
        p_fmt    = req_fmt;
        p_opcode = in_opcode;
        p_funct3 = in_funct3;
        p_funct7 = in_funct7;
        p_rs1    = in_rs1;
        p_rs2    = in_rs2;
        p_imm    = in_imm;
`ifdef INSTR_ENCODER_LI_EN
        if (req_fmt == FMT_LI) begin
            p_funct3 = 3'd0;
            p_funct7 = 7'd0;
            p_rs1    = 5'd0;
            p_rs2    = 5'd0;
            if (li_sext) begin
                p_fmt    = FMT_I;
                p_opcode = OPC_OP_IMM;
                p_imm    = {20'd0, li_lo};
            end else begin
                p_fmt    = FMT_U;
                p_opcode = OPC_LUI;
                p_imm    = {li_hi, 12'd0};
            end
        end
`endif
    end

    instr_field_pack u_pack_main (
        .fmt_i    (p_fmt),
        .opcode_i (p_opcode),
        .funct3_i (p_funct3),
        .funct7_i (p_funct7),
        .rd_i     (in_rd),
        .rs1_i    (p_rs1),
        .rs2_i    (p_rs2),
        .imm_i    (p_imm),
        .instr_o  (first_word)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                // An erroring request is consumed without leaving EMPTY.
                if (load_new) state_d = req_two ? ST_LI_HI : ST_HOLD;
            end
`ifdef INSTR_ENCODER_LI_EN
            ST_LI_HI: begin
                if (out_hs) state_d = ST_LI_LO;
            end
            ST_HOLD, ST_LI_LO: begin
`else
            ST_HOLD: begin
`endif
                if (out_hs) begin
                    if (load_new) state_d = req_two ? ST_LI_HI : ST_HOLD;
                    else          state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q == ST_EMPTY) ||
                    (((state_q == ST_HOLD) || (state_q == ST_LI_LO)) && out_ready);
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        instr_d = instr_q;
        last_d  = last_q;
        if (load_new) begin
            instr_d = first_word;
            last_d  = !req_two;
`ifdef INSTR_ENCODER_LI_EN
        end else if ((state_q == ST_LI_HI) && out_hs) begin
            instr_d = lo_word_q;
            last_d  = 1'b1;
`endif
        end
        err_d   = accept && req_err;
        count_d = out_hs ? count_q + COUNT_W'(1) : count_q;
    end

`ifdef INSTR_ENCODER_LI_EN
    assign lo_word_d = load_new ? addi_word : lo_word_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
`ifdef INSTR_ENCODER_LI_EN
            // NOTE: the pending ADDI word is reset too so a mid-LI reset leaves no stale word behind.
            lo_word_q <= '0;
`endif
        end else begin
            instr_q   <= instr_d;
            last_q    <= last_d;
            err_q     <= err_d;
            count_q   <= count_d;
`ifdef INSTR_ENCODER_LI_EN
            lo_word_q <= lo_word_d;
`endif
        end
    end

    assign out_instr  = instr_q;
    assign out_last   = last_q;
    assign err        = err_q;
    assign emit_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder: directed cases plus randomized
// requests compared against a value-level reference model.
// Honours INSTR_ENCODER_LI_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

`ifdef INSTR_ENCODER_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;
    logic [15:0] emit_count;

    instr_encoder #(.COUNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_last   (out_last),
        .err        (err),
        .emit_count (emit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        last;
        int          cyc;
    } word_t;

    word_t       exp_q[$];
    word_t       obs_q[$];
    logic [15:0] model_count = '0;
    logic        err_exp = 1'b0;
    int          cyc = 0;
    bit          rand_ready = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference packer written from the bit-field tables using shifts and masks.
    function automatic logic [31:0] ref_pack(input int fmt, input logic [31:0] op,
                                             input logic [31:0] f3, input logic [31:0] f7,
                                             input logic [31:0] rd, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [31:0] imm);
        logic [31:0] base;
        base = (f3 << 12) | (rs1 << 15) | op;
        case (fmt)
            0: return base | (f7 << 25) | (rs2 << 20) | (rd << 7);
            1: return base | ((imm & 32'hFFF) << 20) | (rd << 7);
            2: return base | (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((imm & 32'h1F) << 7);
            3: return base | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (rs2 << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
            4: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
            5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] w, input logic last);
        word_t e;
        e.w = w; e.last = last; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    // Model of one accepted request (reads the driven input fields).
    task automatic model_accept();
        logic [31:0] imm, lo, hi;
        bit          bad;
        int          f;
        imm = in_imm;
        f   = int'(in_fmt);
        bad = ((f == 3 || f == 5) && imm[0]) || (f == 7) || (f == 6 && !LI_EN);
        if (bad) begin
            err_exp = 1'b1;
        end else if (f == 6) begin
            lo = imm & 32'hFFF;
            hi = (imm + 32'h800) >> 12;
            if ($signed(imm) >= -2048 && $signed(imm) < 2048)
                push_exp(ref_pack(1, 32'h13, 0, 0, 32'(in_rd), 0, 0, lo), 1'b1);
            else if (lo == 0)
                push_exp(ref_pack(4, 32'h37, 0, 0, 32'(in_rd), 0, 0, hi << 12), 1'b1);
            else begin
                push_exp(ref_pack(4, 32'h37, 0, 0, 32'(in_rd), 0, 0, hi << 12), 1'b0);
                push_exp(ref_pack(1, 32'h13, 0, 0, 32'(in_rd), 32'(in_rd), 0, lo), 1'b1);
            end
        end else begin
            push_exp(ref_pack(f, 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                              32'(in_rd), 32'(in_rs1), 32'(in_rs2), imm), 1'b1);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        word_t e, o;
        if (rst_n) begin
            cyc++;
            check("err", err, err_exp);
            err_exp = 1'b0;
            if (out_valid && out_ready) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("instr", out_instr, e.w);
                    check("last", out_last, e.last);
                end
                check("emit_count", emit_count, model_count);
                model_count++;
                o.w = out_instr; o.last = out_last; o.cyc = cyc;
                obs_q.push_back(o);
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1; in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic last,
                               output int at_cyc);
        word_t o;
        bit    got;
        got = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (obs_q.size() > 0) got = 1'b1;
            else tick();
        end
        check({tag, "_seen"}, got, 1);
        if (got) begin
            o = obs_q.pop_front();
            check(tag, o.w, w);
            check({tag, "_last"}, o.last, last);
            at_cyc = o.cyc;
        end
    endtask

    task automatic expect_err_pulse(input string tag);
        @(negedge clk);
        check(tag, {err, out_valid}, 2'b10);
        tick();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        check("drain", done, 1);
        obs_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        obs_q.delete();
        model_count = '0;
        err_exp = 1'b0;
        check("rst_outputs", {out_valid, out_instr, out_last, err, emit_count},
              {1'b0, 32'h0, 1'b0, 1'b0, 16'h0});
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, c1;
        logic [2:0]  rf;
        logic [31:0] rimm;
        apply_reset();
        tick();

        // R then I back to back with out_ready high.
        out_ready = 1'b1;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("add", 32'h002081B3, 1'b1, c0);
        expect_word("addi", 32'h00500093, 1'b1, c1);
        check("b2b_consecutive", c1 - c0, 1);
        check("b2b_count", emit_count, 16'd2);
        drain();

        // Branch and jump.
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word("beq", 32'h00208463, 1'b1, c0);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        expect_word("jal", 32'h001000EF, 1'b1, c0);
        drain();

        // LI variants.
        if (LI_EN) begin
            send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
            check("li2_in_ready_low", in_ready, 0);
            expect_word("li2_lui", 32'h123462B7, 1'b0, c0);
            expect_word("li2_addi", 32'hFFF28293, 1'b1, c1);
            send(3'd6, 7'h00, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd100);
            expect_word("li_small", 32'h06400193, 1'b1, c0);
            send(3'd6, 7'h00, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'h00001000);
            expect_word("li_lui", 32'h00001237, 1'b1, c0);
            drain();
        end else begin
            send(3'd6, 7'h00, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd100);
            expect_err_pulse("li_disabled_err");
            drain();
        end

        // Back-pressure: word pending with out_ready low.
        out_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, out_instr, in_ready}, {1'b1, 32'h002081B3, 1'b0});
            check("bp_count", emit_count, model_count);
            tick();
        end
        out_ready = 1'b1;
        expect_word("bp_release", 32'h002081B3, 1'b1, c0);
        drain();

        // Errors: misaligned branch and reserved format.
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        expect_err_pulse("b_odd_err");
        send(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        expect_err_pulse("rsv_err");
        check("err_count_frozen", emit_count, model_count);
        drain();

        // Reset in the middle of a request.
        if (LI_EN) begin
            send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
            expect_word("rst_li_lui", 32'h123462B7, 1'b0, c0);
        end else begin
            out_ready = 1'b0;
            send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        end
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
            tick();
        end
        check("post_rst_no_word", obs_q.size(), 0);

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       rimm = $urandom() & 32'hFFFF_F000;
                2:       rimm = $urandom();
                default: rimm = $urandom() & 32'hFFFF_FFFE;
            endcase
            send(rf, 7'($urandom()), 3'($urandom()), 7'($urandom()), 5'($urandom()),
                 5'($urandom()), 5'($urandom()), rimm);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", emit_count, model_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
